// File: rtl/sdspi_read_bench.sv
`timescale 1ns/1ps
// Read engine for the SD SPI throughput campaign: reads n_blocks 512-byte blocks
// through the sdspi host (repeated single-block reads or one CMD18 multi-block read)
// and reports finish/err plus a byte count and a modulo-2^32 byte checksum.
module sdspi_read_bench #(
  parameter logic [31:0] START_BLOCK = 32'h00100000,
  parameter int unsigned BLOCK_BYTES = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] n_blocks,
  input  logic [4:0]  sclk_speed,
  input  logic        cmd18,
  output logic        finish,
  output logic        err,
  output logic [31:0] bytes_read,
  output logic [31:0] checksum,
  input  logic        spi_busy,
  input  logic [7:0]  spi_data_out,
  input  logic        spi_err,
  output logic [31:0] spi_block_addr,
  output logic        spi_r_block,
  output logic        spi_r_multi_block,
  output logic        spi_r_byte,
  output logic [4:0]  spi_sclk_speed
);

  typedef enum logic [3:0] {
    S_IDLE, S_REQ_BLK, S_WAIT_BLK, S_REQ_BYTE, S_WAIT_BYTE, S_NEXT_BLK,
    S_END_BLK, S_STOP, S_STOP_END, S_DONE, S_ERROR
  } state_t;

  localparam logic [9:0] LAST_BYTE = 10'(BLOCK_BYTES - 1);

  state_t      state;
  state_t      next_state;
  logic [31:0] n_blocks_l;
  logic        cmd18_l;
  logic [31:0] blk_idx;
  logic [9:0]  byte_idx;
  logic        running;
  logic        last_byte;
  logic        more_blocks;

  // spi_err and start=0 only act while a transfer is in flight
  assign running     = (state != S_IDLE) && (state != S_DONE) && (state != S_ERROR);
  assign last_byte   = (byte_idx >= LAST_BYTE);
  assign more_blocks = ((blk_idx + 32'd1) < n_blocks_l);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state logic; host error beats abort, abort beats normal progress
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:      if (start) next_state = (n_blocks == 32'd0) ? S_DONE : S_REQ_BLK;
      S_REQ_BLK:   if (spi_busy) next_state = S_WAIT_BLK;
      S_WAIT_BLK:  if (!spi_busy) next_state = S_REQ_BYTE;
      S_REQ_BYTE:  if (spi_busy) next_state = S_WAIT_BYTE;
      S_WAIT_BYTE: begin
        if (!spi_busy) begin
          if (!last_byte)      next_state = S_REQ_BYTE;
          else if (more_blocks) next_state = S_NEXT_BLK;
          else                 next_state = S_END_BLK;
        end
      end
      // multi mode skips the command phase: the host just fetches the next data token
      S_NEXT_BLK:  next_state = cmd18_l ? S_WAIT_BLK : S_REQ_BLK;
      S_END_BLK:   next_state = cmd18_l ? S_STOP : S_DONE;
      // CMD12 from the host shows up as one busy pulse
      S_STOP:      if (spi_busy) next_state = S_STOP_END;
      S_STOP_END:  if (!spi_busy) next_state = S_DONE;
      S_DONE,
      S_ERROR:     if (!start) next_state = S_IDLE;
      default:     next_state = S_IDLE;
    endcase
    if (running) begin
      if (spi_err)     next_state = S_ERROR;
      else if (!start) next_state = S_IDLE;
    end
  end

  // Host request strobes, decoded straight from the state
  always_comb begin
    spi_r_block       = 1'b0;
    spi_r_multi_block = 1'b0;
    spi_r_byte        = 1'b0;
    case (state)
      S_REQ_BLK, S_WAIT_BLK, S_WAIT_BYTE: begin
        spi_r_block       = 1'b1;
        spi_r_multi_block = cmd18_l;
      end
      S_REQ_BYTE: begin
        spi_r_block       = 1'b1;
        spi_r_multi_block = cmd18_l;
        spi_r_byte        = 1'b1;
      end
      // single mode drops r_block here for one cycle to close the block
      S_NEXT_BLK: begin
        spi_r_block       = cmd18_l;
        spi_r_multi_block = cmd18_l;
      end
      default: ;
    endcase
  end

  // Parameter latch, counters, capture and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      n_blocks_l     <= '0;
      cmd18_l        <= 1'b0;
      spi_sclk_speed <= '0;
      blk_idx        <= '0;
      byte_idx       <= '0;
      bytes_read     <= '0;
      checksum       <= '0;
      spi_block_addr <= '0;
      finish         <= 1'b0;
      err            <= 1'b0;
    end else begin
      finish <= (state == S_DONE) || (state == S_ERROR);
      err    <= (state == S_ERROR);
      case (state)
        S_IDLE: begin
          blk_idx        <= '0;
          byte_idx       <= '0;
          bytes_read     <= '0;
          checksum       <= '0;
          spi_block_addr <= start ? START_BLOCK : 32'd0;
          if (start) begin
            n_blocks_l     <= n_blocks;
            cmd18_l        <= cmd18;
            spi_sclk_speed <= sclk_speed;
          end
        end
        S_WAIT_BYTE: begin
          if (!spi_busy) begin
            checksum   <= checksum + {24'd0, spi_data_out};
            bytes_read <= bytes_read + 32'd1;
            byte_idx   <= byte_idx + 10'd1;
          end
        end
        S_NEXT_BLK: begin
          byte_idx       <= '0;
          blk_idx        <= blk_idx + 32'd1;
          spi_block_addr <= cmd18_l ? START_BLOCK : (START_BLOCK + blk_idx + 32'd1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdspi_read_bench.sv
`timescale 1ns/1ps
// Randomized self-checking bench for sdspi_read_bench with a reactive sdspi host model.
// Expected counts and checksums come from block/byte arithmetic over the host data pattern.
module tb_sdspi_read_bench;

  localparam logic [31:0] START = 32'h00100000;
  localparam int LIMIT = 20000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] n_blocks = '0;
  logic [4:0]  sclk_speed = '0;
  logic        cmd18 = 1'b0;
  logic        finish, err;
  logic [31:0] bytes_read, checksum;
  logic        spi_busy = 1'b0;
  logic [7:0]  spi_data_out = '0;
  logic        spi_err = 1'b0;
  logic [31:0] spi_block_addr;
  logic        spi_r_block, spi_r_multi_block, spi_r_byte;
  logic [4:0]  spi_sclk_speed;

  sdspi_read_bench dut (
    .clk(clk), .rst(rst), .start(start), .n_blocks(n_blocks), .sclk_speed(sclk_speed),
    .cmd18(cmd18), .finish(finish), .err(err), .bytes_read(bytes_read), .checksum(checksum),
    .spi_busy(spi_busy), .spi_data_out(spi_data_out), .spi_err(spi_err),
    .spi_block_addr(spi_block_addr), .spi_r_block(spi_r_block),
    .spi_r_multi_block(spi_r_multi_block), .spi_r_byte(spi_r_byte),
    .spi_sclk_speed(spi_sclk_speed)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nfail = 0;

  // host control (written by the main sequence)
  bit host_clr = 1'b0;
  bit run_multi = 1'b0;
  int err_at = -1;
  int lat_max = 2;
  int pat_mode = 0;
  int pat_seed = 0;
  int pat_mul = 1;

  // host state and observations (written by the host process)
  int  h_cnt, h_blk, h_byte, h_total;
  bit  h_active, h_stop_pend, h_in_stop, h_prev_rb, h_prev_multi, h_seen_rb;
  int  lo_run, gap_n, gap_last, addr_bad, multi_drop;
  bit  stop_seen, stop_fin;
  logic [31:0] addr_log[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // host data pattern: byte i of the b-th block read in this run
  function automatic logic [7:0] dat(int b, int i);
    if (pat_mode == 0) return 8'(i);
    return 8'(i * pat_mul + b * 37 + pat_seed);
  endfunction

  function automatic logic [31:0] exp_sum(int nb);
    logic [31:0] s = 0;
    for (int b = 0; b < nb; b++)
      for (int i = 0; i < 512; i++) s += 32'(dat(b, i));
    return s;
  endfunction

  // Host: busy for 1..lat_max cycles per request, CMD12 pulse after a multi-block read
  initial begin
    forever begin
      @(negedge clk);
      spi_err = 1'b0;
      if (host_clr) begin
        spi_busy = 1'b0; spi_data_out = '0;
        h_cnt = 0; h_blk = 0; h_byte = 0; h_total = 0;
        h_active = 0; h_stop_pend = 0; h_in_stop = 0; h_prev_rb = 0; h_prev_multi = 0; h_seen_rb = 0;
        lo_run = 0; gap_n = 0; gap_last = 0; addr_bad = 0; multi_drop = 0;
        stop_seen = 0; stop_fin = 0;
        addr_log.delete();
      end else begin
        if (spi_r_block) begin
          if (h_seen_rb && lo_run > 0) begin gap_n++; gap_last = lo_run; end
          lo_run = 0;
          h_seen_rb = 1;
          if (run_multi && spi_block_addr != START) addr_bad++;
          if (run_multi && !spi_r_multi_block) multi_drop++;
        end else if (h_seen_rb) begin
          lo_run++;
        end
        if (h_cnt > 0) begin
          h_cnt--;
          if (h_cnt == 0) begin
            spi_busy = 1'b0;
            if (h_in_stop) begin h_in_stop = 0; stop_seen = 1; stop_fin = finish; end
          end
        end else if (h_stop_pend) begin
          h_stop_pend = 0; h_in_stop = 1;
          spi_busy = 1'b1; h_cnt = $urandom_range(lat_max, 1);
        end else if (spi_r_block && !h_active) begin
          h_active = 1; h_byte = 0;
          h_blk = spi_r_multi_block ? 0 : int'(spi_block_addr - START);
          addr_log.push_back(spi_block_addr);
          spi_busy = 1'b1; h_cnt = $urandom_range(lat_max, 1);
        end else if (spi_r_byte) begin
          if (h_byte == 512) begin h_byte = 0; h_blk++; end
          spi_data_out = dat(h_blk, h_byte);
          if (h_total == err_at) spi_err = 1'b1;
          h_byte++; h_total++;
          spi_busy = 1'b1; h_cnt = $urandom_range(lat_max, 1);
        end
        if (!spi_r_block && h_prev_rb && h_prev_multi) h_stop_pend = 1;
        if (!spi_r_block) h_active = 0;
        h_prev_rb = spi_r_block;
        h_prev_multi = spi_r_multi_block;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic launch(input int nb, input bit m, input logic [4:0] sp);
    host_clr = 1'b1;
    tick(1);
    host_clr = 1'b0;
    run_multi = m; n_blocks = nb; cmd18 = m; sclk_speed = sp; start = 1'b1;
  endtask

  task automatic wait_finish(output int cyc);
    cyc = 0;
    while (finish !== 1'b1 && cyc < LIMIT) begin tick(1); cyc++; end
    chk("finish_timeout", 32'(cyc < LIMIT), 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_finish"}, 32'(finish), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_bytes"}, bytes_read, 32'd0);
    chk({tag, "_sum"}, checksum, 32'd0);
    chk({tag, "_addr"}, spi_block_addr, 32'd0);
    chk({tag, "_req"}, 32'({spi_r_block, spi_r_multi_block, spi_r_byte}), 32'd0);
  endtask

  initial begin
    int cyc, w, nb;
    bit m;
    logic [4:0] sp;

    // reset state
    tick(3);
    check_idle_outputs("reset");
    chk("reset_sclk", 32'(spi_sclk_speed), 32'd0);
    rst = 1'b0;
    tick(2);

    // two single-block reads
    launch(2, 1'b0, 5'd9);
    wait_finish(cyc);
    chk("s2_nblk", addr_log.size(), 32'd2);
    if (addr_log.size() == 2) begin
      chk("s2_addr0", addr_log[0], START);
      chk("s2_addr1", addr_log[1], START + 32'd1);
    end
    chk("s2_gap_n", gap_n, 32'd1);
    chk("s2_gap_len", gap_last, 32'd1);
    chk("s2_bytes", bytes_read, 32'd1024);
    chk("s2_sum", checksum, 32'h0001FE00);
    chk("s2_fin_err", 32'({finish, err}), 32'b10);
    chk("s2_sclk", 32'(spi_sclk_speed), 32'd9);
    start = 1'b0;
    tick(3);
    chk("s2_clr_fin", 32'(finish), 32'd0);
    chk("s2_clr_bytes", bytes_read, 32'd0);

    // one three-block CMD18 read
    launch(3, 1'b1, 5'd3);
    wait_finish(cyc);
    chk("m3_nblk", addr_log.size(), 32'd1);
    chk("m3_addr_bad", addr_bad, 32'd0);
    chk("m3_multi_drop", multi_drop, 32'd0);
    chk("m3_gap_n", gap_n, 32'd0);
    chk("m3_stop_seen", 32'(stop_seen), 32'd1);
    chk("m3_stop_fin", 32'(stop_fin), 32'd0);
    chk("m3_bytes", bytes_read, 32'd1536);
    chk("m3_sum", checksum, 32'h0002FD00);
    chk("m3_fin_err", 32'({finish, err}), 32'b10);
    start = 1'b0;
    tick(3);

    // zero blocks
    launch(0, 1'b0, 5'd1);
    wait_finish(cyc);
    chk("z_latency", cyc, 32'd2);
    chk("z_bytes", bytes_read, 32'd0);
    chk("z_no_rblk", 32'(h_seen_rb), 32'd0);
    start = 1'b0;
    tick(3);

    // host error during byte 100 of block 0
    err_at = 100;
    launch(2, 1'b0, 5'd4);
    wait_finish(cyc);
    err_at = -1;
    chk("e_err", 32'(err), 32'd1);
    chk("e_bytes", 32'(bytes_read == 32'd100 || bytes_read == 32'd101), 32'd1);
    chk("e_req", 32'({spi_r_block, spi_r_multi_block, spi_r_byte}), 32'd0);
    start = 1'b0;
    tick(3);
    check_idle_outputs("e_clr");

    // abort in block 1 of 4, then a clean single block
    m = 1'($urandom);
    launch(4, m, 5'd2);
    w = 0;
    while (h_total < 600 && w < LIMIT) begin tick(1); w++; end
    chk("a_reach", 32'(w < LIMIT), 32'd1);
    start = 1'b0;
    tick(1);
    chk("a_req", 32'({spi_r_block, spi_r_multi_block, spi_r_byte}), 32'd0);
    chk("a_fin", 32'(finish), 32'd0);
    tick(3);
    launch(1, m, 5'd2);
    wait_finish(cyc);
    chk("a_bytes", bytes_read, 32'd512);
    chk("a_addr", addr_log.size() > 0 ? addr_log[0] : 32'hFFFFFFFF, START);
    chk("a_sum", checksum, exp_sum(1));
    start = 1'b0;
    tick(3);

    // reset in WAIT_BYTE, then a clean run
    launch(2, 1'b0, 5'd7);
    w = 0;
    while (!(h_total >= 50 && spi_r_block && !spi_r_byte) && w < LIMIT) begin tick(1); w++; end
    chk("r_reach", 32'(w < LIMIT), 32'd1);
    rst = 1'b1;
    start = 1'b0;
    tick(1);
    check_idle_outputs("r_mid");
    chk("r_mid_sclk", 32'(spi_sclk_speed), 32'd0);
    rst = 1'b0;
    tick(2);
    pat_mode = 1; pat_seed = int'($urandom_range(255, 0)); pat_mul = 3;
    launch(1, 1'b0, 5'd5);
    wait_finish(cyc);
    chk("r_bytes", bytes_read, 32'd512);
    chk("r_sum", checksum, exp_sum(1));
    start = 1'b0;
    tick(3);

    // randomized runs; inputs scrambled mid-run must not matter
    lat_max = 3;
    for (int k = 0; k < 3; k++) begin
      nb = int'($urandom_range(2, 1));
      m = 1'($urandom);
      sp = 5'($urandom);
      pat_seed = int'($urandom_range(255, 0));
      pat_mul = 2 * int'($urandom_range(60, 0)) + 1;
      launch(nb, m, sp);
      tick(2);
      n_blocks = $urandom_range(9, 3);
      cmd18 = ~m;
      sclk_speed = ~sp;
      wait_finish(cyc);
      chk("rnd_bytes", bytes_read, 32'(nb * 512));
      chk("rnd_sum", checksum, exp_sum(nb));
      chk("rnd_err", 32'(err), 32'd0);
      chk("rnd_sclk", 32'(spi_sclk_speed), 32'(sp));
      chk("rnd_nblk", addr_log.size(), m ? 32'd1 : 32'(nb));
      start = 1'b0;
      tick(3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
